// File: rtl/alu_rr_scheduler_pkg.sv
// Shared types for the ALU round-robin scheduler: op codes, flag bit
// positions and the scheduler FSM state encoding.
package alu_sched_pkg;

    typedef enum logic [3:0] {
        OP_DIV = 4'b0000,
        OP_MUL = 4'b0001,
        OP_SUB = 4'b0010,
        OP_ADD = 4'b0011,
        OP_AND = 4'b0100,
        OP_SHR = 4'b0101,
        OP_SHL = 4'b0110,
        OP_MOD = 4'b0111,
        OP_OR  = 4'b1010,
        OP_XOR = 4'b1011
    } op_t;

    // Bit positions inside the 4-bit {Z,C,N,O} flag word
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Codes 1000, 1001, 1100..1111 have no ALU meaning and are rejected
    function automatic logic is_legal_op(op_t op);
        case (op)
            OP_DIV, OP_MUL, OP_SUB, OP_ADD, OP_AND,
            OP_SHR, OP_SHL, OP_MOD, OP_OR, OP_XOR: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request starting at i_ptr
// and wrapping modulo N. Purely combinational; the pointer lives in the caller.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan i_ptr, i_ptr+1, ... (mod N) and keep the first hit
    always_comb begin
        logic [IW-1:0] w_j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int k = 0; k < N; k++) begin
            w_j = IW'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one calculator ALU between N requesters. A round-robin arbiter
// grants one request in IDLE; the operands are held on the ALU for LAT
// cycles, then result/flags/id are returned on a single response channel.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Producers hold valid and payload until that edge; ready never depends on
// the same channel's valid through a register, and a response's fields stay
// frozen while rsp_valid is high and rsp_ready is low.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int M   = 4,
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*M-1:0]       req_a,
    input  logic [N*M-1:0]       req_b,
    input  logic [N*4-1:0]       req_sel,
    output logic [M-1:0]         alu_a,
    output logic [M-1:0]         alu_b,
    output logic [3:0]           alu_sel,
    input  logic [M-1:0]         alu_res,
    input  logic [3:0]           alu_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [M-1:0]         rsp_res,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int IW = $clog2(N);

    state_t        r_state, w_next;
    logic [IW-1:0] r_ptr, r_id;
    logic [2:0]    r_cnt;
    logic [M-1:0]  r_op_a, r_op_b;
    logic [3:0]    r_op_sel;
    logic [M-1:0]  r_rsp_res;
    logic [3:0]    r_rsp_flags;
    logic          r_rsp_err;
    logic [IW-1:0] r_rsp_id;

    logic [N-1:0]  w_grant;
    logic [IW-1:0] w_gidx, w_ptr_next;
    logic          w_any, w_legal, w_cnt_done, w_accept;
    logic [M-1:0]  w_req_a, w_req_b;
    logic [3:0]    w_req_sel;

    rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign w_req_a    = req_a[w_gidx*M +: M];
    assign w_req_b    = req_b[w_gidx*M +: M];
    assign w_req_sel  = req_sel[w_gidx*4 +: 4];
    assign w_legal    = is_legal_op(op_t'(w_req_sel));
    assign w_cnt_done = (r_cnt == 3'(LAT - 1));
    assign w_ptr_next = (w_gidx == IW'(N - 1)) ? '0 : w_gidx + 1'b1;
    // Reset wins over an accept, so no grant is advertised while it is high
    assign w_accept   = (r_state == IDLE) && w_any && !rst;

    assign req_ready  = w_accept ? w_grant : '0;
    assign alu_a      = r_op_a;
    assign alu_b      = r_op_b;
    assign alu_sel    = r_op_sel;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_res    = r_rsp_res;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != IDLE);
    assign dbg_state  = r_state;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: illegal ops skip EXEC and answer immediately with an error
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = w_legal ? EXEC : RESP;
            EXEC:    if (w_cnt_done) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand, pointer, counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_sel    <= '0;
            r_rsp_res   <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id  <= w_gidx;
                        r_ptr <= w_ptr_next;
                        r_cnt <= '0;
                        if (w_legal) begin
                            // ALU inputs only move on a legal op
                            r_op_a   <= w_req_a;
                            r_op_b   <= w_req_b;
                            r_op_sel <= w_req_sel;
                        end else begin
                            r_rsp_res   <= '0;
                            r_rsp_flags <= '0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_id    <= w_gidx;
                        end
                    end
                end
                EXEC: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (w_cnt_done) begin
                        r_rsp_res   <= alu_res;
                        r_rsp_flags <= alu_flags;
                        r_rsp_err   <= 1'b0;
                        r_rsp_id    <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: one LAT=1 instance and one LAT=3
// instance, each fed by a behavioural calculator ALU.
module tb_alu_rr_scheduler;

    logic clk;
    int   n_tests;
    int   n_fail;

    // ---------------- LAT=1 instance ----------------
    logic        rst;
    logic [3:0]  req_valid, req_ready;
    logic [15:0] req_a, req_b, req_sel;
    logic [3:0]  alu_a, alu_b, alu_sel, alu_res, alu_flags;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [1:0]  rsp_id, dbg_state;
    logic [3:0]  rsp_res, rsp_flags;

    // ---------------- LAT=3 instance ----------------
    logic        rst_3;
    logic [3:0]  req_valid_3, req_ready_3;
    logic [15:0] req_a_3, req_b_3, req_sel_3;
    logic [3:0]  alu_a_3, alu_b_3, alu_sel_3, alu_res_3, alu_flags_3;
    logic        rsp_valid_3, rsp_ready_3, rsp_err_3, busy_3;
    logic [1:0]  rsp_id_3, dbg_state_3;
    logic [3:0]  rsp_res_3, rsp_flags_3;

    alu_rr_scheduler #(.M(4), .N(4), .LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_res(alu_res), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    alu_rr_scheduler #(.M(4), .N(4), .LAT(3)) dut_3 (
        .clk(clk), .rst(rst_3),
        .req_valid(req_valid_3), .req_ready(req_ready_3),
        .req_a(req_a_3), .req_b(req_b_3), .req_sel(req_sel_3),
        .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_sel(alu_sel_3),
        .alu_res(alu_res_3), .alu_flags(alu_flags_3),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_id(rsp_id_3),
        .rsp_res(rsp_res_3), .rsp_flags(rsp_flags_3), .rsp_err(rsp_err_3),
        .busy(busy_3), .dbg_state(dbg_state_3)
    );

    // Calculator ALU: returns {Z,C,N,O, result}
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] sel);
        logic [4:0] s;
        logic [7:0] p;
        logic [3:0] r;
        logic       c, o;
        s = '0; p = '0; r = '0; c = 1'b0; o = 1'b0;
        case (sel)
            4'b0011: begin
                s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                o = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'b0010: begin
                s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
                o = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'b0001: begin p = {4'b0, a} * {4'b0, b}; r = p[3:0]; c = |p[7:4]; end
            4'b0000: r = (b != 0) ? a / b : 4'd0;
            4'b0111: r = (b != 0) ? a % b : 4'd0;
            4'b0100: r = a & b;
            4'b1010: r = a | b;
            4'b1011: r = a ^ b;
            4'b0101: r = a >> b;
            4'b0110: begin p = {4'b0, a} << b; r = p[3:0]; c = |p[7:4]; end
            default: r = '0;
        endcase
        return {(r == 4'd0), c, r[3], o, r};
    endfunction

    always_comb {alu_flags, alu_res}     = alu_model(alu_a, alu_b, alu_sel);
    always_comb {alu_flags_3, alu_res_3} = alu_model(alu_a_3, alu_b_3, alu_sel_3);

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, required completion before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; rst_3 = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
        req_valid_3 = '0; req_a_3 = '0; req_b_3 = '0; req_sel_3 = '0; rsp_ready_3 = 1'b0;
        repeat (2) tick();
        #1;
        n_tests++;
        if ({alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_err,
             req_ready, busy, dbg_state} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {alu_a, alu_b, alu_sel, rsp_valid,
                     rsp_id, rsp_res, rsp_flags, rsp_err, req_ready, busy, dbg_state});
        end
        n_tests++;
        if ({alu_a_3, alu_b_3, alu_sel_3, rsp_valid_3, rsp_id_3, rsp_res_3, rsp_flags_3,
             rsp_err_3, req_ready_3, busy_3, dbg_state_3} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat3: got %h want 0", {alu_a_3, alu_b_3, alu_sel_3,
                     rsp_valid_3, rsp_id_3, rsp_res_3, rsp_flags_3, rsp_err_3, req_ready_3,
                     busy_3, dbg_state_3});
        end
        rst = 1'b0; rst_3 = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_a[3:0] = 4'd3; req_b[3:0] = 4'd4; req_sel[3:0] = 4'b0011;
        req_valid = 4'b0001;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL single_ready_once: got %b want 0000", req_ready);
        end
        n_tests++;
        if ({alu_a, alu_b, alu_sel, busy, rsp_valid} !== {4'd3, 4'd4, 4'b0011, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_exec: got a=%h b=%h sel=%b busy=%b v=%b want 3 4 0011 1 0",
                     alu_a, alu_b, alu_sel, busy, rsp_valid);
        end
        tick();
        #1;
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_err} !== {1'b1, 2'd0, 4'd7, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL single_rsp: got v=%b id=%0d res=%h fl=%b err=%b want 1 0 7 0000 0",
                     rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_err);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        n_tests++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL single_done: got v=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready [6];
        int         exp_id [6];
        int         exp_res [6];
        exp_ready = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_id    = '{0, 1, 2, 3, 0, 1};
        exp_res   = '{3, 4, 5, 6, 3, 4};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*4 +: 4]   = 4'(i + 1);
            req_b[i*4 +: 4]   = 4'd2;
            req_sel[i*4 +: 4] = 4'b0011;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_tests++;
            if (req_ready !== exp_ready[k]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_ready[k]);
            end
            tick();
            #1;
            n_tests++;
            if (req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL rr_exec_ready[%0d]: got %b want 0000", k, req_ready);
            end
            tick();
            #1;
            n_tests++;
            if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 2'(exp_id[k]), 4'(exp_res[k])}) begin
                n_fail++;
                $display("FAIL rr_rsp[%0d]: got v=%b id=%0d res=%0d want 1 %0d %0d",
                         k, rsp_valid, rsp_id, rsp_res, exp_id[k], exp_res[k]);
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        req_a[7:4] = 4'd6; req_b[7:4] = 4'd11; req_sel[7:4] = 4'b1011;
        req_valid = 4'b0010;
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_grant: got %b want 0010", req_ready);
        end
        tick();
        req_a[11:8] = 4'd1; req_b[11:8] = 4'd1; req_sel[11:8] = 4'b0011;
        req_valid = 4'b0100;
        #1;
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL bp_exec_ready: got %b want 0000", req_ready);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++;
            if ({rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_err, req_ready}
                    !== {1'b1, 2'd1, 4'b1101, 4'b0010, 1'b0, 4'b0000}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d res=%b fl=%b err=%b rdy=%b want 1 1 1101 0010 0 0000",
                         k, rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_err, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        n_tests++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'b0100}) begin
            n_fail++;
            $display("FAIL bp_port2_next: got v=%b rdy=%b want 0 0100", rsp_valid, req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        #1;
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 2'd2, 4'd2}) begin
            n_fail++;
            $display("FAIL bp_port2_rsp: got v=%b id=%0d res=%0d want 1 2 2", rsp_valid, rsp_id, rsp_res);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_illegal();
        req_a[11:8] = 4'd5; req_b[11:8] = 4'd5; req_sel[11:8] = 4'b1100;
        req_valid = 4'b0100;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL illegal_grant: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_err} !== {1'b1, 2'd2, 4'd0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_rsp: got v=%b id=%0d res=%h fl=%b err=%b want 1 2 0 0000 1",
                     rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_err);
        end
        n_tests++;
        if ({alu_a, alu_sel} !== {4'd1, 4'b0011}) begin
            n_fail++;
            $display("FAIL illegal_alu_hold: got a=%h sel=%b want 1 0011", alu_a, alu_sel);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        n_tests++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL illegal_done: got v=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_exec();
        req_a_3[15:12] = 4'd3; req_b_3[15:12] = 4'd2; req_sel_3[15:12] = 4'b0001;
        req_valid_3 = 4'b1000;
        #1;
        n_tests++;
        if (req_ready_3 !== 4'b1000) begin
            n_fail++; $display("FAIL rstx_grant: got %b want 1000", req_ready_3);
        end
        tick();
        #1;
        n_tests++;
        if ({busy_3, alu_sel_3} !== {1'b1, 4'b0001}) begin
            n_fail++; $display("FAIL rstx_exec: got busy=%b sel=%b want 1 0001", busy_3, alu_sel_3);
        end
        tick();
        rst_3 = 1'b1;
        tick();
        #1;
        n_tests++;
        if ({alu_a_3, alu_b_3, alu_sel_3, rsp_valid_3, rsp_id_3, rsp_res_3, rsp_flags_3,
             rsp_err_3, req_ready_3, busy_3, dbg_state_3} !== 31'd0) begin
            n_fail++;
            $display("FAIL rstx_cleared: got v=%b busy=%b rdy=%b a=%h sel=%b want all 0",
                     rsp_valid_3, busy_3, req_ready_3, alu_a_3, alu_sel_3);
        end
        rst_3 = 1'b0;
        #1;
        n_tests++;
        if (req_ready_3 !== 4'b1000) begin
            n_fail++; $display("FAIL rstx_regrant: got %b want 1000", req_ready_3);
        end
        tick();
        req_valid_3 = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (rsp_valid_3 !== 1'b0) begin
                n_fail++; $display("FAIL rstx_no_early_rsp[%0d]: got %b want 0", k, rsp_valid_3);
            end
            tick();
        end
        #1;
        n_tests++;
        if ({rsp_valid_3, rsp_id_3, rsp_res_3, rsp_flags_3, rsp_err_3}
                !== {1'b1, 2'd3, 4'd6, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL rstx_rsp: got v=%b id=%0d res=%0d fl=%b err=%b want 1 3 6 0000 0",
                     rsp_valid_3, rsp_id_3, rsp_res_3, rsp_flags_3, rsp_err_3);
        end
        rsp_ready_3 = 1'b1;
        tick();
        rsp_ready_3 = 1'b0;
    endtask

    task automatic test_lat3();
        req_a_3[3:0] = 4'd2; req_b_3[3:0] = 4'd3; req_sel_3[3:0] = 4'b0010;
        req_valid_3 = 4'b0001;
        #1;
        n_tests++;
        if (req_ready_3 !== 4'b0001) begin
            n_fail++; $display("FAIL lat3_grant: got %b want 0001", req_ready_3);
        end
        tick();
        req_valid_3 = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if ({alu_a_3, alu_b_3, alu_sel_3, rsp_valid_3} !== {4'd2, 4'd3, 4'b0010, 1'b0}) begin
                n_fail++;
                $display("FAIL lat3_exec[%0d]: got a=%h b=%h sel=%b v=%b want 2 3 0010 0",
                         k, alu_a_3, alu_b_3, alu_sel_3, rsp_valid_3);
            end
            tick();
        end
        #1;
        n_tests++;
        if ({rsp_valid_3, rsp_id_3, rsp_res_3, rsp_flags_3, rsp_err_3}
                !== {1'b1, 2'd0, 4'b1111, 4'b0110, 1'b0}) begin
            n_fail++;
            $display("FAIL lat3_rsp: got v=%b id=%0d res=%b fl=%b err=%b want 1 0 1111 0110 0",
                     rsp_valid_3, rsp_id_3, rsp_res_3, rsp_flags_3, rsp_err_3);
        end
        rsp_ready_3 = 1'b1;
        tick();
        rsp_ready_3 = 1'b0;
        #1;
        n_tests++;
        if (rsp_valid_3 !== 1'b0) begin
            n_fail++; $display("FAIL lat3_done: got %b want 0", rsp_valid_3);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_reset_exec();
        test_lat3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
